// File: rtl/wave_gen_pkg.sv
// wave_gen_pkg: shared FSM states, step record and default parameters for wave_stim_gen
package wave_gen_pkg;
   localparam int DEPTH_DEF = 8;
   localparam int DUR_W_DEF = 8;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   typedef struct packed {
      logic [2:0]           val;
      logic [DUR_W_DEF-1:0] dur;
   } step_t;
endpackage

// File: rtl/wave_stim_gen_if.sv
// wave_stim_gen_if: host/table and waveform bundle; loop exists only with WAVE_GEN_LOOP_EN
interface wave_stim_gen_if
   import wave_gen_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DUR_W = DUR_W_DEF,
   parameter int AW    = $clog2(DEPTH)
) ();
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [2:0]       wr_val;
   logic [DUR_W-1:0] wr_dur;
   logic [AW:0]      len;
   logic             start;
   logic             stop;
`ifdef WAVE_GEN_LOOP_EN
   logic             loop;
`endif
   logic             a, b, c;
   logic             busy;
   logic             done;
   logic [AW-1:0]    step_idx;
   modport master (
      output wr_en, wr_addr, wr_val, wr_dur, len, start, stop,
`ifdef WAVE_GEN_LOOP_EN
      output loop,
`endif
      input  a, b, c, busy, done, step_idx
   );
   modport slave (
      input  wr_en, wr_addr, wr_val, wr_dur, len, start, stop,
`ifdef WAVE_GEN_LOOP_EN
      input  loop,
`endif
      output a, b, c, busy, done, step_idx
   );
endinterface

// File: rtl/wave_gen_dur_cnt.sv
// wave_gen_dur_cnt: loadable hold-time down-counter; a loaded 0 behaves as 1
module wave_gen_dur_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] value,
   input  logic         en,
   output logic         expire
);
   logic [W-1:0] cnt;
   assign expire = cnt == '0;
   // load holds max(value,1)-1 remaining cycles, otherwise count down to zero
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else if (load) cnt <= (value == '0) ? '0 : value - 1'b1;
      else if (en && !expire) cnt <= cnt - 1'b1;
   end
endmodule

// File: rtl/wave_stim_gen.sv
// wave_stim_gen: step-table waveform sequencer for a/b/c; WAVE_GEN_LOOP_EN adds looping playback
module wave_stim_gen
   import wave_gen_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF,
   parameter int DUR_W = DUR_W_DEF
) (
   input logic            clk,
   input logic            rst,
   wave_stim_gen_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   step_t            tbl [DEPTH];
   state_t           state, nstate;
   logic [AW-1:0]    idx, nidx, nxt, last;
   logic [AW:0]      len_c;
   logic [DUR_W-1:0] ld_dur;
   logic             ld, expire, loop_on;
`ifdef WAVE_GEN_LOOP_EN
   assign loop_on = bus.loop;
`else
   assign loop_on = 1'b0;
`endif
   assign nxt = idx + 1'b1;
   assign len_c = (bus.len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.len;
   assign bus.step_idx = idx;
   wave_gen_dur_cnt #(.W(DUR_W)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (ld),
      .value  (ld_dur),
      .en     (state == RUN),
      .expire (expire)
   );
   // table accepts host writes only while idle; contents survive reset
   always_ff @(posedge clk) begin
      if (bus.wr_en && state == IDLE) tbl[bus.wr_addr] <= '{val: bus.wr_val, dur: DUR_W_DEF'(bus.wr_dur)};
   end
   // next state, next step index and counter reload; stop beats advance and start
   always_comb begin
      nstate = state;
      nidx   = '0;
      ld     = 1'b0;
      ld_dur = DUR_W'(tbl[0].dur);
      case (state)
         IDLE: if (bus.start && !bus.stop && len_c != '0) begin
            nstate = RUN;
            ld     = 1'b1;
         end
         RUN: if (bus.stop) begin
            nstate = IDLE;
            ld     = 1'b1;
            ld_dur = '0;
         end else if (!expire) nidx = idx;
         else if (idx != last) begin
            nidx   = nxt;
            ld     = 1'b1;
            ld_dur = DUR_W'(tbl[nxt].dur);
         end else if (loop_on) ld = 1'b1;
         else nstate = DONE;
         default: nstate = IDLE;
      endcase
   end
   // registered state and outputs; last step index latched while idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= IDLE;
         idx                   <= '0;
         last                  <= '0;
         {bus.a, bus.b, bus.c} <= 3'b0;
         bus.busy              <= 1'b0;
         bus.done              <= 1'b0;
      end else begin
         state                 <= nstate;
         idx                   <= nidx;
         {bus.a, bus.b, bus.c} <= (nstate == RUN) ? tbl[nidx].val : 3'b0;
         bus.busy              <= nstate == RUN;
         bus.done              <= nstate == DONE;
         if (state == IDLE) last <= AW'(len_c - 1'b1);
      end
   end
endmodule

// File: tb/tb_wave_stim_gen.sv
// tb_wave_stim_gen: directed checks of reset, playback, clamp, abort, len=0 and loop
module tb_wave_stim_gen;
   localparam int DEPTH = 8;
   localparam int DUR_W = 8;
   localparam int AW    = 3;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] abc;
   int         total = 0;
   int         bad = 0;
   always #5 clk = ~clk;
   wave_stim_gen_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();
   wave_stim_gen #(.DEPTH(DEPTH), .DUR_W(DUR_W)) dut (.clk(clk), .rst(rst), .bus(bus));
   assign abc = {bus.a, bus.b, bus.c};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(input logic [AW-1:0] ad, input logic [2:0] v, input logic [DUR_W-1:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ad;
      bus.wr_val  = v;
      bus.wr_dur  = d;
      tick();
      bus.wr_en = 1'b0;
   endtask
   task automatic idle_chk(input string tag);
      chk(tag, {abc, bus.busy, bus.done, 1'b0, bus.step_idx}, 32'h0);
   endtask
   initial begin
      logic [2:0] exp_abc [6] = '{3'b100, 3'b100, 3'b011, 3'b111, 3'b111, 3'b111};
      logic [2:0] exp_idx [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd2, 3'd2};
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_val = '0; bus.wr_dur = '0;
      bus.len = 4'd3; bus.start = 1'b1; bus.stop = 1'b0;
`ifdef WAVE_GEN_LOOP_EN
      bus.loop = 1'b0;
`endif
      rst = 1'b1;
      tick();
      idle_chk("reset1");
      tick();
      idle_chk("reset2");
      rst = 1'b0; bus.start = 1'b0;
      tick();
      idle_chk("post_reset");
      wr(3'd0, 3'b100, 8'd2);
      wr(3'd1, 3'b011, 8'd1);
      wr(3'd2, 3'b111, 8'd3);
      bus.len = 4'd3; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("basic_abc%0d", i), abc, exp_abc[i]);
         chk($sformatf("basic_busy_idx%0d", i), {bus.busy, bus.done, bus.step_idx}, {2'b10, exp_idx[i]});
         tick();
      end
      chk("basic_done", {abc, bus.busy, bus.done}, 5'b00001);
      tick();
      idle_chk("basic_idle");
      wr(3'd0, 3'b101, 8'd0);
      for (int i = 1; i < DEPTH; i++) wr(AW'(i), 3'(i), 8'd1);
      bus.len = 4'(DEPTH + 3); bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("clamp_abc%0d", i), abc, (i == 0) ? 3'b101 : 3'(i));
         chk($sformatf("clamp_busy_idx%0d", i), {bus.busy, bus.done, bus.step_idx}, {2'b10, 3'(i)});
         tick();
      end
      chk("clamp_done", {abc, bus.busy, bus.done}, 5'b00001);
      tick();
      idle_chk("clamp_idle");
      wr(3'd0, 3'b110, 8'd10);
      bus.len = 4'd1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      repeat (3) tick();
      chk("abort_run", {abc, bus.busy}, 4'b1101);
      bus.stop = 1'b1; bus.start = 1'b1;
      bus.wr_en = 1'b1; bus.wr_addr = 3'd0; bus.wr_val = 3'b001; bus.wr_dur = 8'd3;
      tick();
      bus.stop = 1'b0; bus.start = 1'b0; bus.wr_en = 1'b0;
      idle_chk("abort_out");
      for (int i = 0; i < 3; i++) begin
         tick();
         idle_chk($sformatf("abort_quiet%0d", i));
      end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("abort_tbl_val", {abc, bus.busy}, 4'b1101);
      repeat (9) tick();
      chk("abort_tbl_dur", {abc, bus.busy, bus.done}, 5'b11010);
      tick();
      chk("abort_tbl_done", {abc, bus.busy, bus.done}, 5'b00001);
      tick();
      bus.len = 4'd0; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         idle_chk($sformatf("len0_%0d", i));
         tick();
      end
`ifdef WAVE_GEN_LOOP_EN
      wr(3'd0, 3'b001, 8'd1);
      wr(3'd1, 3'b010, 8'd1);
      bus.len = 4'd2; bus.loop = 1'b1; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("loop_%0d", i), {abc, bus.busy, bus.done}, {(i % 2 == 0) ? 3'b001 : 3'b010, 2'b10});
         tick();
      end
      bus.loop = 1'b0;
      chk("loop_end0", {abc, bus.busy, bus.done}, 5'b00110);
      tick();
      chk("loop_end1", {abc, bus.busy, bus.done}, 5'b01010);
      tick();
      chk("loop_done", {abc, bus.busy, bus.done}, 5'b00001);
      tick();
      idle_chk("loop_idle");
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
